c_unary_stream: RTL

C_UNARY_STREAM -- requirements
Module: c_unary_stream

---
 rtl/c_pkg.sv | 17 +
 rtl/c_unary_chunk.sv | 81 ++++++++
 rtl/c_unary_stream.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/c_pkg.sv
// Shared types and helpers for the unary stream decoder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package c_pkg;

    // Top-level control states: gathering beats, or presenting a result.
    typedef enum logic {
        ACCUM  = 1'b0,
        RESULT = 1'b1
    } state_t;

    // Number of bits needed to hold a count from 0 to w inclusive.
    function automatic int cnt_w(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/c_unary_chunk.sv
// Evaluates one beat of a unary vector against the carry from earlier beats.
// Latency: purely combinational, no registers.
// Backpressure: none; the caller decides when the result is committed.
//
// Ports:
//   chunk         beat data, bit 0 is the lowest vector bit of this beat
//   first         this is beat 0 of the vector (bit 0 must equal the lead value)
//   cin_*         carry-in: still admissible, edge already seen, all bits terminal
//                 so far, value of the previous vector bit
//   cout_*        same quantities after folding in this beat
//   part_cnt      number of lead-valued bits inside this beat
module c_unary_chunk
    import c_pkg::*;
#(
    parameter int P_CHUNK         = 4,
    parameter int P_IS_COMPLIMENT = 0
) (
    input  logic [P_CHUNK-1:0]          chunk,
    input  logic                        first,
    input  logic                        cin_admit,
    input  logic                        cin_edge_seen,
    input  logic                        cin_all_term,
    input  logic                        cin_prev,
    output logic                        cout_admit,
    output logic                        cout_edge_seen,
    output logic                        cout_all_term,
    output logic                        cout_prev,
    output logic [cnt_w(P_CHUNK)-1:0]   part_cnt
);

    localparam int   PCW  = cnt_w(P_CHUNK);
    localparam logic LEAD = (P_IS_COMPLIMENT == 0) ? 1'b1 : 1'b0;
    localparam logic TERM = ~LEAD;

    logic           admit;
    logic           edge_seen;
    logic           all_term;
    logic           prev;
    logic           bit_v;
    logic [PCW-1:0] cnt;

    always_comb begin
        admit     = cin_admit;
        edge_seen = cin_edge_seen;
        all_term  = cin_all_term;
        prev      = cin_prev;
        bit_v     = 1'b0;
        cnt       = '0;
        for (int i = 0; i < P_CHUNK; i++) begin
            bit_v = chunk[i];
            if (first && (i == 0)) begin
                // Vector bit 0 has no predecessor; it simply has to be the lead value.
                if (bit_v != LEAD) begin
                    admit = 1'b0;
                end
            end else if (bit_v != prev) begin
                // The only legal change is a single lead->terminal step; any
                // second change (or a terminal->lead step) disqualifies the vector.
                if ((prev == LEAD) && !edge_seen) begin
                    edge_seen = 1'b1;
                end else begin
                    admit = 1'b0;
                end
            end
            if (bit_v != TERM) begin
                all_term = 1'b0;
            end
            if (bit_v == LEAD) begin
                cnt = cnt + PCW'(1);
            end
            prev = bit_v;
        end
    end

    assign cout_admit     = admit;
    assign cout_edge_seen = edge_seen;
    assign cout_all_term  = all_term;
    assign cout_prev      = chunk[P_CHUNK-1];
    assign part_cnt       = cnt;

endmodule

// File: rtl/c_unary_stream.sv
// Streams a P_W-bit unary code in P_CHUNK-bit beats (LSB chunk first) and decodes it.
// Latency: result valid 1 cycle after the final beat; P_W/P_CHUNK cycles first beat to result.
// Backpressure: result held while i_rdy=0; o_rdy=(state==ACCUM)|i_rdy so next beat overlaps consume.
//
// Ports:
//   i_clk, i_arst_n   clock, asynchronous active-low reset
//   i_vld/o_rdy/i_data  input beat handshake and data
//   o_vld/i_rdy       result handshake
//   o_is_unary        vector was a valid unary code
//   o_count           number of lead bits when unary, else 0
//   o_all_term        every vector bit equals the terminal value
//   o_reject_cnt      saturating count of consumed non-unary results
//                     (present only when C_UNARY_STREAM_STATS_EN is defined)
module c_unary_stream
    import c_pkg::*;
#(
    parameter int P_W             = 16,
    parameter int P_CHUNK         = 4,
    parameter int P_IS_COMPLIMENT = 0
) (
    input  logic                    i_clk,
    input  logic                    i_arst_n,
    input  logic                    i_vld,
    input  logic [P_CHUNK-1:0]      i_data,
    output logic                    o_rdy,
    output logic                    o_vld,
    input  logic                    i_rdy,
    output logic                    o_is_unary,
    output logic [cnt_w(P_W)-1:0]   o_count,
    output logic                    o_all_term
`ifdef C_UNARY_STREAM_STATS_EN
    ,
    output logic [15:0]             o_reject_cnt
`endif
);

    localparam int   NB   = P_W / P_CHUNK;
    localparam int   BW   = (NB > 1) ? $clog2(NB) : 1;
    localparam int   CW   = cnt_w(P_W);
    localparam int   PCW  = cnt_w(P_CHUNK);
    localparam logic LEAD = (P_IS_COMPLIMENT == 0) ? 1'b1 : 1'b0;

    state_t          state;
    state_t          state_nxt;
    logic [BW-1:0]   beat_cnt;

    // Running accumulators for the vector being gathered.
    logic            acc_admit;
    logic            acc_edge_seen;
    logic            acc_all_term;
    logic            acc_prev;
    logic [CW-1:0]   acc_cnt;

    // Registered result, held while waiting for the consumer.
    logic            res_is_unary;
    logic [CW-1:0]   res_count;
    logic            res_all_term;

    logic            accept;
    logic            consume;
    logic            first_beat;
    logic            last_beat;

    logic            cin_admit;
    logic            cin_edge_seen;
    logic            cin_all_term;
    logic            cin_prev;
    logic [CW-1:0]   cin_cnt;

    logic            cout_admit;
    logic            cout_edge_seen;
    logic            cout_all_term;
    logic            cout_prev;
    logic [PCW-1:0]  part_cnt;
    logic [CW-1:0]   sum_cnt;
    logic            fin_unary;

    assign o_vld      = (state == RESULT);
    assign o_rdy      = (state == ACCUM) | i_rdy;
    assign accept     = i_vld & o_rdy;
    assign consume    = o_vld & i_rdy;
    assign first_beat = (beat_cnt == '0);
    assign last_beat  = (beat_cnt == BW'(NB - 1));

    // Beat 0 starts from fresh carry values, so nothing from the previous
    // vector can leak in even though the accumulators are not cleared on consume.
    assign cin_admit     = first_beat ? 1'b1 : acc_admit;
    assign cin_edge_seen = first_beat ? 1'b0 : acc_edge_seen;
    assign cin_all_term  = first_beat ? 1'b1 : acc_all_term;
    assign cin_prev      = first_beat ? LEAD : acc_prev;
    assign cin_cnt       = first_beat ? '0   : acc_cnt;

    c_unary_chunk #(
        .P_CHUNK         (P_CHUNK),
        .P_IS_COMPLIMENT (P_IS_COMPLIMENT)
    ) u_chunk (
        .chunk          (i_data),
        .first          (first_beat),
        .cin_admit      (cin_admit),
        .cin_edge_seen  (cin_edge_seen),
        .cin_all_term   (cin_all_term),
        .cin_prev       (cin_prev),
        .cout_admit     (cout_admit),
        .cout_edge_seen (cout_edge_seen),
        .cout_all_term  (cout_all_term),
        .cout_prev      (cout_prev),
        .part_cnt       (part_cnt)
    );

    assign sum_cnt = cin_cnt + CW'(part_cnt);
    // With bit 0 = lead and exactly one lead->terminal step, the top bit is
    // necessarily terminal, so admit & edge_seen is the full unary test.
    assign fin_unary = cout_admit & cout_edge_seen;

    always_comb begin
        state_nxt = state;
        if (accept && last_beat) begin
            // Also covers a single-beat vector arriving as the old result leaves.
            state_nxt = RESULT;
        end else if (consume) begin
            state_nxt = ACCUM;
        end
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state <= ACCUM;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            beat_cnt      <= '0;
            acc_admit     <= 1'b0;
            acc_edge_seen <= 1'b0;
            acc_all_term  <= 1'b0;
            acc_prev      <= 1'b0;
            acc_cnt       <= '0;
        end else if (accept) begin
            beat_cnt      <= last_beat ? '0 : beat_cnt + BW'(1);
            acc_admit     <= cout_admit;
            acc_edge_seen <= cout_edge_seen;
            acc_all_term  <= cout_all_term;
            acc_prev      <= cout_prev;
            acc_cnt       <= sum_cnt;
        end
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            res_is_unary <= 1'b0;
            res_count    <= '0;
            res_all_term <= 1'b0;
        end else if (accept && last_beat) begin
            res_is_unary <= fin_unary;
            res_count    <= fin_unary ? sum_cnt : '0;
            res_all_term <= cout_all_term;
        end
    end

    assign o_is_unary = res_is_unary;
    assign o_count    = res_count;
    assign o_all_term = res_all_term;

`ifdef C_UNARY_STREAM_STATS_EN
    logic [15:0] reject_cnt;

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            reject_cnt <= '0;
        end else if (consume && !res_is_unary && (reject_cnt != 16'hFFFF)) begin
            reject_cnt <= reject_cnt + 16'd1;
        end
    end

    assign o_reject_cnt = reject_cnt;
`endif

endmodule
